// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch widths, fetch FSM encoding, opcodes.
package mips_pkg;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC selection for the held instruction: jump > taken branch > pc+4.
module next_pc_gen #(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic [31:0]     instr,
    input  logic            Jump,
    input  logic            Branch,
    input  logic            zero,
    output logic [PC_W-1:0] nextPc
);

    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] jumpTgt;
    logic [PC_W-1:0] brOff;
    logic [PC_W-1:0] brTgt;

    // Candidate targets; all arithmetic wraps modulo 2^PC_W.
    always_comb begin
        pc4     = pc + PC_W'(4);
        jumpTgt = {pc4[PC_W-1:28], instr[25:0], 2'b00};
        brOff   = {{(PC_W-18){instr[15]}}, instr[15:0], 2'b00};
        brTgt   = pc4 + brOff;
    end

    // Redirect priority; a branch with zero clear falls through to pc+4.
    always_comb begin
        if (Jump)
            nextPc = jumpTgt;
        else if (Branch && zero)
            nextPc = brTgt;
        else
            nextPc = pc4;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue unit: owns the PC, reads imem over req/ready, holds the word
// for decode and applies the redirect decided for that word.
module instr_fetch_unit #(
    parameter int              PC_W     = mips_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = mips_pkg::RESET_PC[PC_W-1:0]
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [5:0]      Op,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            Jump,
    input  logic            Branch,
    input  logic            zero
);
    import mips_pkg::*;

    fetch_state_t    state, stateNext;
    logic [PC_W-1:0] nextPc;
    logic            fetchDone;
    logic            issueDone;

    assign fetchDone = (state == S_REQ)  && imem_ready;
    assign issueDone = (state == S_HOLD) && !stall;

    next_pc_gen #(.PC_W(PC_W)) uNextPc (
        .pc     (pc),
        .instr  (instr),
        .Jump   (Jump),
        .Branch (Branch),
        .zero   (zero),
        .nextPc (nextPc)
    );

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_RST;
        else
            state <= stateNext;
    end

    // Next state: single outstanding fetch, issue once, then refetch.
    always_comb begin
        stateNext = state;
        case (state)
            S_RST:   stateNext = S_REQ;
            S_REQ:   if (imem_ready) stateNext = S_HOLD;
            S_HOLD:  if (!stall)     stateNext = S_REQ;
            default: stateNext = S_RST;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            S_REQ:   imem_req    = 1'b1;
            S_HOLD:  instr_valid = 1'b1;
            default: ;
        endcase
    end

    // PC advances only when decode accepts the held instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else if (issueDone)
            pc <= nextPc;
    end

    // Instruction register captures the returned word on the ready cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instr <= 32'd0;
        else if (fetchDone)
            instr <= imem_rdata;
    end

    assign imem_addr = pc;
    assign Op        = instr[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: directed cases then random traffic.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [5:0]  Op;
    logic        instr_valid;
    logic [31:0] pc;
    logic        stall = 1'b0;
    logic        Jump = 1'b0;
    logic        Branch = 1'b0;
    logic        zero = 1'b0;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } issue_t;

    issue_t      expQ[$];
    logic [31:0] modelPc;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .Op(Op), .instr_valid(instr_valid), .pc(pc),
        .stall(stall), .Jump(Jump), .Branch(Branch), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference next-PC straight from the ISA definition.
    function automatic logic [31:0] refNext(input logic [31:0] p, input logic [31:0] w,
                                            input logic j, input logic b, input logic z);
        logic [31:0] p4;
        int          imm;
        p4  = p + 32'd4;
        imm = int'($signed(w[15:0]));
        if (j)           return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        else if (b && z) return p4 + 32'(imm * 4);
        else             return p4;
    endfunction

    // One complete fetch/issue transaction driven from the memory/decode side.
    task automatic fetchOne(input logic [31:0] w, input int waits, input int stalls,
                            input logic j, input logic b, input logic z, input int pulseAt);
        int t;
        t = 0;
        while (!imem_req && t < 10) begin step(); t++; end
        if (!imem_req) begin chk("reqTimeout", 32'(imem_req), 32'd1); return; end
        chk("imemAddr", imem_addr, modelPc);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            step();
            chk("waitReq", 32'(imem_req), 32'd1);
            chk("waitAddr", imem_addr, modelPc);
            chk("waitValid", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = w;
        expQ.push_back('{pc: modelPc, instr: w});
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        for (int i = 0; i < stalls; i++) begin
            stall  = 1'b1;
            Jump   = (i == pulseAt) ? 1'b1 : 1'($urandom_range(0, 1));
            Branch = 1'($urandom_range(0, 1));
            zero   = 1'($urandom_range(0, 1));
            step();
            chk("stallValid", 32'(instr_valid), 32'd1);
            chk("stallPc", pc, modelPc);
            chk("stallInstr", instr, w);
        end
        stall  = 1'b0;
        Jump   = j;
        Branch = b;
        zero   = z;
        modelPc = refNext(modelPc, w, j, b, z);
        step();
        Jump = 1'b0; Branch = 1'b0; zero = 1'b0;
        chk("validDrop", 32'(instr_valid), 32'd0);
    endtask

    // Monitor: each rising instr_valid must match the oldest expected issue.
    initial begin
        logic   prevValid;
        issue_t e;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    chk("unexpectedIssue", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("issuePc", pc, e.pc);
                    chk("issueInstr", instr, e.instr);
                    chk("issueOp", 32'(Op), 32'(e.instr[31:26]));
                end
            end
            prevValid = instr_valid && !rst;
        end
    end

    initial begin
        logic [31:0] w;
        logic [5:0]  opc;
        modelPc = 32'd0;

        // Reset with memory claiming ready.
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (3) step();
        chk("rstValid", 32'(instr_valid), 32'd0);
        chk("rstInstr", instr, 32'd0);
        chk("rstPc", pc, 32'd0);
        chk("rstReq", 32'(imem_req), 32'd0);
        imem_ready = 1'b0;
        rst = 1'b0;
        step();
        chk("firstReq", 32'(imem_req), 32'd1);
        chk("firstAddr", imem_addr, 32'd0);

        // Reset mid-request, ready during reset ignored.
        imem_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        chk("midRstValid", 32'(instr_valid), 32'd0);
        chk("midRstInstr", instr, 32'd0);
        chk("midRstPc", pc, 32'd0);
        imem_ready = 1'b0;
        rst = 1'b0;
        step();

        // Sequential zero-wait fetch.
        for (int i = 0; i < 3; i++) fetchOne(32'h2008_0005, 0, 0, 0, 0, 0, -1);
        chk("seqOp", 32'(Op), 32'd8);
        // Wait states, then stall with a mid-stall jump pulse.
        fetchOne(32'h2008_0005, 4, 0, 0, 0, 0, -1);
        fetchOne(32'h0800_0000, 0, 5, 0, 0, 0, 2);
        chk("stallJumpIgnored", imem_addr, 32'h14);

        // Jump from 0x0040_0010.
        fetchOne({OP_J, 26'h010_0004}, 0, 0, 1, 0, 0, -1);
        chk("jumpSetup", imem_addr, 32'h0040_0010);
        fetchOne(32'h0810_0000, 0, 0, 1, 0, 0, -1);
        chk("jumpTarget", imem_addr, 32'h0040_0000);

        // Branch taken / not taken at 0x100, then jump and branch together.
        fetchOne({OP_J, 26'h40}, 0, 0, 1, 0, 0, -1);
        fetchOne(32'h1000_FFFE, 0, 0, 0, 1, 1, -1);
        chk("branchTaken", imem_addr, 32'h0000_00FC);
        fetchOne(32'h2008_0005, 0, 0, 0, 0, 0, -1);
        fetchOne(32'h1000_FFFE, 0, 0, 0, 1, 0, -1);
        chk("branchNotTaken", imem_addr, 32'h0000_0104);
        fetchOne(32'h1000_FFFE, 0, 0, 1, 1, 1, -1);
        chk("jumpOverBranch", imem_addr, 32'h0003_FFF8);

        // Wrap: reach 0xFFFF_FFFC via backward branch from 0.
        fetchOne({OP_J, 26'h0}, 0, 0, 1, 0, 0, -1);
        fetchOne(32'h1000_FFFE, 0, 0, 0, 1, 1, -1);
        chk("wrapSetup", imem_addr, 32'hFFFF_FFFC);
        fetchOne(32'h2008_0005, 0, 0, 0, 0, 0, -1);
        chk("wrapTarget", imem_addr, 32'h0000_0000);

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0:       opc = OP_RTYPE;
                1:       opc = OP_J;
                2:       opc = OP_BEQ;
                default: opc = 6'($urandom);
            endcase
            w = {opc, 26'($urandom)};
            fetchOne(w, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                     1'($urandom_range(0, 1) & $urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        step();
        chk("queueDrained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and issue unit for the MIPS core. It produces the `Op` field consumed by the `Control` decoder, so it is the upstream end of that interface. It holds the PC, issues instruction-memory reads over a request/ready handshake, and holds the fetched word stable for decode. It applies the `Jump`/`Branch` redirect returned for the issued instruction.

## Interface
- `PC_W`, 32, PC and address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk  in  1`  rising-edge clock
- `rst  in  1`  reset, asynchronous, active-high
- `imem_req  out  1`  memory read request
- `imem_addr  out  PC_W`  word-aligned read address (= `pc`)
- `imem_ready  in  1`  memory returns `imem_rdata` this cycle
- `imem_rdata  in  32`  instruction word
- `instr  out  32`  held instruction word
- `Op  out  6`  `instr[31:26]`, feeds `Control`
- `instr_valid  out  1`  `instr`/`Op` valid for decode
- `pc  out  PC_W`  address of the held instruction
- `stall  in  1`  decode cannot accept; hold the current instruction
- `Jump  in  1`  from `Control` for the held instruction
- `Branch  in  1`  from `Control`
- `zero  in  1`  ALU zero flag; the branch is taken when `Branch & zero`

## Operation
- FSM states: `S_RST`, `S_REQ`, `S_HOLD`.
- **S_RST**
  - Entered asynchronously on `rst`.
  - Outputs: `pc=RESET_PC`, `instr=0`, `instr_valid=0`, `imem_req=0`.
  - Next cycle after `rst` deasserts: go to `S_REQ`.
- **S_REQ**
  - `imem_req=1`, `imem_addr=pc`.
  - On `imem_ready`: latch `imem_rdata` into `instr`, then go to `S_HOLD`.
  - Without `imem_ready`: wait indefinitely with `pc` constant.
- **S_HOLD**
  - `instr_valid=1`, `imem_req=0`.
  - While `stall=1`: remain in `S_HOLD`, all outputs constant, and `Jump`/`Branch`/`zero` ignored.
  - When `stall=0`:
    - Update `pc <= next_pc`.
    - Drop `instr_valid` the next cycle.
    - Go to `S_REQ`.
- **next_pc** (computed from the held instruction only)
  - `pc4 = pc + 4`, modulo 2^PC_W; `0xFFFF_FFFC` wraps to `0`.
  - Jump target: `{pc4[31:28], instr[25:0], 2'b00}`.
  - Branch target: `pc4 + (sign_extend(instr[15:0]) << 2)`, modulo 2^PC_W.
  - Priority: `Jump` > (`Branch & zero`) > `pc4`.
  - `Branch & ~zero` selects `pc4`.
- Each fetched word is issued exactly once; there is no prefetch and no duplicate issue.
- Reset mid-request: the request is abandoned and any `imem_ready` during `rst` is ignored. Fetch restarts at `RESET_PC`.

## Timing
- All state updates occur on `posedge clk`. Reset is asynchronous.
- Reset release to the first `imem_req=1`: 1 cycle (`S_RST` → `S_REQ`).
- Memory latency: `instr_valid` rises the cycle after the `imem_ready` cycle.
- Issue rate with zero-wait memory and no stall: one instruction every 2 cycles.
- `instr`, `Op`, and `pc` change only on the `S_REQ` → `S_HOLD` and `S_HOLD` → `S_REQ` edges.
- `Op` is combinational from `instr`. `imem_addr` is combinational from `pc`.
- Redirect inputs are sampled only in the `S_HOLD & ~stall` cycle. A redirect asserted during stall has no effect until that cycle.

## Structure
- Shared package `mips_pkg`:
  - `PC_W`, `RESET_PC`
  - state enum `fetch_state_t`
  - opcode constants `OP_RTYPE=6'd0`, `OP_J=6'd2`, `OP_BEQ=6'd4`, used by the bench.
- One natural sub-module: `next_pc_gen`, combinational (`pc`, `instr`, `Jump`, `Branch`, `zero` → `next_pc`).
- Top level holds the FSM, PC register, and instruction register.

## Test plan
- **Reset:** assert `rst` for 3 cycles mid-`S_REQ` with `imem_ready=1` → `instr_valid=0`, `instr=0`, `pc=0`. First `imem_addr` after release is `0x0`.
- **Sequential fetch:** zero-wait memory returning `0x2008_0005`, no redirect → `pc` sequence 0, 4, 8. `Op=6'd8`. `instr_valid` pulses every 2 cycles.
- **Wait states:** hold `imem_ready=0` for 4 cycles → `imem_req` stays 1, `imem_addr` stays constant, `instr_valid` stays 0 until 1 cycle after ready.
- **Stall:**
  - Setup: hold `stall=1` for 5 cycles in `S_HOLD` with `Jump=1` pulsed mid-stall.
  - Expect: `instr` and `pc` unchanged during the stall, and the `Jump` pulse is ignored.
- **Jump:** `pc=0x0040_0010`, `instr=0x0810_0000`, `Jump=1` → next `pc=0x0040_0000`.
- **Branch taken:**
  - Setup: `pc=0x100`, `instr=0x1000_FFFE`, `Branch=1`, `zero=1`.
  - Expect: next `pc=0x0FC`.
- **Branch not taken:** same setup with `zero=0` → next `pc=0x104`.
- **Jump and branch together:** `Jump=1` with `Branch=1`, `zero=1` → the jump target is selected.
- **Wrap:** `pc=0xFFFF_FFFC`, no redirect → next `pc=0x0`.
